// File: rtl/axis_dwidth_128to32_if.sv
// AXI4-Stream bundle shared by the 128-bit input and 32-bit output sides of
// axis_dwidth_128to32.
//   tdata  : 8*DataBytes bits, byte 0 in bits [7:0]
//   tkeep  : one enable per byte
//   tlast  : end of packet
//   tvalid : source has a beat
//   tready : sink can take a beat
// master drives the payload and tvalid; slave drives tready.
interface axis_dwidth_128to32_if #(
    parameter int unsigned DataBytes = 16
) ();
    logic [8*DataBytes-1:0] tdata;
    logic [DataBytes-1:0]   tkeep;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_dwidth_128to32.sv
// 128-bit to 32-bit AXI4-Stream width downsizer.
// A beat is buffered and then emitted one 4-byte lane per output handshake,
// least-significant lane first. Lanes above the highest kept lane are
// dropped. tlast goes out with the last emitted lane.
// Ports:
//   clk        : clock
//   reset      : synchronous, active-high
//   s_axis     : 128-bit input stream (slave modport, DataBytes = 16)
//   m_axis     : 32-bit output stream (master modport, DataBytes = 4)
//   pkt_count  : number of output beats sent with tlast, wraps at 16 bits
//   err_keep   : sticky flag, set when an accepted tkeep is not of the form 2^k-1
module axis_dwidth_128to32 (
    input  logic                          clk,
    input  logic                          reset,
    axis_dwidth_128to32_if.slave          s_axis,
    axis_dwidth_128to32_if.master         m_axis,
    output logic [15:0]                   pkt_count,
    output logic                          err_keep
);

    typedef enum logic [0:0] {StEmpty, StDrain} state_e;

    state_e       state_q;
    logic [127:0] data_q;
    logic [15:0]  keep_q;
    logic         last_q;
    logic [1:0]   idx_q;
    logic [1:0]   nl_q;
    logic [31:0]  out_data_q;
    logic [3:0]   out_keep_q;
    logic         out_last_q;

    logic         at_last;
    logic         in_hs;
    logic         out_hs;
    logic         load;
    logic         keep_bad;
    logic [1:0]   in_nl;
    logic [1:0]   idx_next;
    logic [16:0]  keep_ext;

    assign at_last  = (idx_q == nl_q);
    assign idx_next = idx_q + 2'd1;

    // Combinational from m_axis.tready so the next beat is taken on the same
    // edge as the final lane handshake, avoiding a bubble.
    assign s_axis.tready = !reset &&
                           ((state_q == StEmpty) ||
                            ((state_q == StDrain) && at_last && m_axis.tready));

    assign in_hs  = s_axis.tvalid && s_axis.tready;
    assign out_hs = (state_q == StDrain) && m_axis.tready;

    // A zero-keep beat without tlast carries nothing and is swallowed.
    assign load = in_hs && ((s_axis.tkeep != 16'h0) || s_axis.tlast);

    // 2^k-1 patterns are exactly those where keep & (keep+1) is zero.
    assign keep_ext = {1'b0, s_axis.tkeep};
    assign keep_bad = |(keep_ext & (keep_ext + 17'd1));

    // Highest lane holding any kept byte; 0 when tkeep is all zero.
    always_comb begin
        in_nl = 2'd0;
        for (int l = 0; l < 4; l++) begin
            if (|s_axis.tkeep[4*l +: 4]) begin
                in_nl = 2'(l);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StEmpty;
            data_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
            idx_q      <= 2'd0;
            nl_q       <= 2'd0;
            out_data_q <= '0;
            out_keep_q <= '0;
            out_last_q <= 1'b0;
            pkt_count  <= '0;
            err_keep   <= 1'b0;
        end else begin
            if (in_hs && keep_bad) begin
                err_keep <= 1'b1;
            end
            if (out_hs && out_last_q) begin
                pkt_count <= pkt_count + 16'd1;
            end

            if (load) begin
                state_q    <= StDrain;
                data_q     <= s_axis.tdata;
                keep_q     <= s_axis.tkeep;
                last_q     <= s_axis.tlast;
                idx_q      <= 2'd0;
                nl_q       <= in_nl;
                out_data_q <= s_axis.tdata[31:0];
                out_keep_q <= s_axis.tkeep[3:0];
                out_last_q <= s_axis.tlast && (in_nl == 2'd0);
            end else if (out_hs) begin
                if (!at_last) begin
                    idx_q      <= idx_next;
                    out_data_q <= data_q[{idx_next, 5'b0} +: 32];
                    out_keep_q <= keep_q[{idx_next, 2'b0} +: 4];
                    out_last_q <= last_q && (idx_next == nl_q);
                end else begin
                    state_q <= StEmpty;
                end
            end
        end
    end

    assign m_axis.tdata  = out_data_q;
    assign m_axis.tkeep  = out_keep_q;
    assign m_axis.tlast  = out_last_q;
    assign m_axis.tvalid = (state_q == StDrain);

endmodule

// File: doc/axis_dwidth_128to32.md
# axis_dwidth_128to32

Stream width downsizer placed directly downstream of the mm2s block. It accepts the 128-bit AXI4-Stream output of mm2s (tdata/tkeep/tlast) and re-emits it as a 32-bit AXI4-Stream, least-significant 4-byte lane first. Empty trailing lanes are dropped and tlast is preserved. Once the first beat is buffered, output throughput is one 32-bit beat per clock with no bubbles between input beats. Two status outputs report packet count and a sticky tkeep-format error.

## Interface
- No parameters; widths fixed at 128 in / 32 out.
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- s_axis_tdata  in  128  input data, byte 0 = bits [7:0].
- s_axis_tkeep  in  16  input byte enables.
- s_axis_tlast  in  1  end of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  32  output data.
- m_axis_tkeep  out  4  output byte enables.
- m_axis_tlast  out  1  end of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- pkt_count  out  16  number of output beats sent with tlast=1; wraps 0xFFFF→0.
- err_keep  out  1  sticky; set when an accepted input beat has tkeep not of the form 2^k−1 (k = 0..16).

## Operation
- Holding register: tdata, tkeep, tlast, lane index idx[1:0], last lane nl[1:0].
- States:
  - EMPTY: m_axis_tvalid=0, s_axis_tready=1.
  - DRAIN: m_axis_tvalid=1.
- Input accept (tvalid & tready):
  - Load the holding register and set idx=0.
  - nl = index of the highest 4-byte lane with any keep bit set.
  - If tkeep=0: without tlast, the beat is dropped and the state does not change. With tlast, it is emitted as one output beat (tkeep=0, tlast=1).
- Output in DRAIN:
  - m_axis_tdata = tdata[32·idx+31 : 32·idx].
  - m_axis_tkeep = tkeep[4·idx+3 : 4·idx], passed through unmodified, including zero lanes below nl.
  - m_axis_tlast = held tlast & (idx==nl).
- Output handshake with idx<nl: idx increments.
- Output handshake with idx==nl:
  - If an input beat is accepted in the same cycle, reload and stay in DRAIN.
  - Otherwise go to EMPTY.
- s_axis_tready = EMPTY | (DRAIN & idx==nl & m_axis_tready). This path is combinational from m_axis_tready.
- pkt_count increments on each output handshake with m_axis_tlast=1.
- err_keep is set on an accepted beat that violates the rule above. It clears only on reset. Data is still passed through.
- Reset, including mid-packet: the held beat is discarded.
  - State = EMPTY, idx=0.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0.
  - pkt_count=0, err_keep=0.
  - s_axis_tready=0 while reset is high and 1 on the first cycle after.

## Timing
- Latency: input accepted at edge N → m_axis_tvalid=1 after edge N (visible in cycle N+1).
- Outputs are registered except s_axis_tready.
- Full 128-bit beats: 4 output cycles per input beat. The next input is accepted on the 4th output handshake, so there are no gaps.
- Stall: while m_axis_tready=0, all m_axis_* outputs are held stable and s_axis_tready=0 in DRAIN.
- tvalid is never withdrawn once asserted until the handshake completes.
- No input is accepted during reset or in the cycle reset is asserted.

## Test plan
- 6-byte packet: one input beat, tkeep=0x003F, tlast=1, data bytes 0x00..0x0F.
  - Expect 2 output beats: 0x03020100/keep 0xF/last 0, then 0x07060504/keep 0x3/last 1.
  - Then pkt_count=1, err_keep=0.
- 1028-byte packet, sink always ready: 64 beats with keep 0xFFFF, then 1 beat with keep 0x000F and tlast.
  - Expect 257 contiguous output beats in 257 consecutive cycles after the first.
  - Last beat: keep 0xF, last 1.
  - Byte sequence matches input in order.
- Backpressure: same 1028-byte packet with m_axis_tready toggled by a pseudo-random pattern.
  - Output is identical byte stream.
  - m_axis_* stable during every stall.
  - No input accepted unless idx==nl.
- Sparse keep: one beat, tkeep=0xF00F, tlast=1.
  - Expect 4 output beats with keeps 0xF, 0x0, 0x0, 0xF; last on the 4th.
  - err_keep=1 and remains 1 until reset.
- Zero keep: a beat with tkeep=0, tlast=0 produces no output.
  - A following beat with tkeep=0, tlast=1 produces one output beat with keep 0x0, last 1.
  - pkt_count increments by 1.
- Reset mid-packet: assert reset for 1 cycle after the 2nd output beat of a full beat.
  - All outputs reach their reset values.
  - A new 6-byte packet afterwards is output exactly as in the first scenario, with pkt_count=1.
